// File: rtl/uart_xmit_sched_of_verifla.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte producers.
// Latency: ack_o one cycle after a grantable request; xmitH one cycle after ack_o.
// Backpressure: grants only in IDLE with xmit_doneH high; requests wait otherwise.
//
// Ports:
//   sys_clk, sys_rst_l  clock and synchronous active-low reset
//   req_i / data_i      per-requester byte-ready and byte (requester k on [8k+7:8k])
//   ack_o               one-hot, one-cycle pulse when requester k's byte is latched
//   xmitH / xmit_dataH  launch strobe and held byte toward the UART transmitter
//   xmit_doneH          transmitter ready (high = idle)
//   grant_o / busy_o    last granted index; high while not IDLE
// NREQ must be 2..4.
module uart_xmit_sched_of_verifla #(
  parameter int NREQ         = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_l,
  input  logic [NREQ-1:0]   req_i,
  input  logic [8*NREQ-1:0] data_i,
  output logic [NREQ-1:0]   ack_o,
  output logic              xmitH,
  output logic [7:0]        xmit_dataH,
  input  logic              xmit_doneH,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, nextState;
  logic [1:0]    rrPtr;
  logic [1:0]    pickIdx;
  logic [1:0]    cand;
  logic          pickVld;
  logic          grantNow;
  logic [CW-1:0] toCnt;
  logic [3:0]    reqPad;
  logic [31:0]   dataPad;

  // Pad to the maximum requester count so indexing by a 2-bit index is uniform.
  assign reqPad  = 4'(req_i);
  assign dataPad = 32'(data_i);

  // First requesting index at or above the rr pointer, wrapping around.
  always_comb begin
    pickVld = 1'b0;
    pickIdx = rrPtr;
    cand    = rrPtr;
    for (int i = 0; i < NREQ; i++) begin
      cand = 2'((int'(rrPtr) + i) % NREQ);
      if (!pickVld && reqPad[cand]) begin
        pickVld = 1'b1;
        pickIdx = cand;
      end
    end
  end

  assign grantNow = (state == IDLE) && pickVld && xmit_doneH;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:      if (grantNow) nextState = LAUNCH;
      LAUNCH:    nextState = WAIT_BUSY;
      // A transmitter that never drops done is treated as having sent the byte.
      WAIT_BUSY: begin
        if (!xmit_doneH)                           nextState = WAIT_DONE;
        else if (toCnt == CW'(BUSY_TIMEOUT - 1))   nextState = IDLE;
      end
      // Frame length depends on baud, so no timeout while the UART is busy.
      WAIT_DONE: if (xmit_doneH) nextState = IDLE;
      default:   nextState = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) state <= IDLE;
    else            state <= nextState;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_l) begin
      ack_o      <= '0;
      xmitH      <= 1'b0;
      xmit_dataH <= 8'h00;
      grant_o    <= 2'd0;
      busy_o     <= 1'b0;
      rrPtr      <= 2'd0;
      toCnt      <= '0;
    end else begin
      // ack_o is high during LAUNCH; xmitH follows in the first WAIT_BUSY cycle,
      // so the two strobes can never coincide.
      ack_o  <= grantNow ? (NREQ'(1) << pickIdx) : '0;
      xmitH  <= (state == LAUNCH);
      busy_o <= (nextState != IDLE);
      if (grantNow) begin
        xmit_dataH <= dataPad[{pickIdx, 3'b000} +: 8];
        grant_o    <= pickIdx;
      end
      if (state == LAUNCH) begin
        rrPtr <= 2'((int'(grant_o) + 1) % NREQ);
        toCnt <= '0;
      end else if (state == WAIT_BUSY && xmit_doneH) begin
        toCnt <= toCnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_xmit_sched_of_verifla.sv
module tb_uart_xmit_sched_of_verifla;

  localparam int BT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_l;
  logic [1:0]  req2, ack2, grant2;
  logic [15:0] data2;
  logic        xmitH2, done2, busy2;
  logic [7:0]  xdat2;
  logic [3:0]  req4, ack4;
  logic [1:0]  grant4;
  logic [31:0] data4;
  logic        xmitH4, done4, busy4;
  logic [7:0]  xdat4;

  uart_xmit_sched_of_verifla #(.NREQ(2), .BUSY_TIMEOUT(BT)) dut2 (
    .sys_clk(clk), .sys_rst_l(rst_l), .req_i(req2), .data_i(data2), .ack_o(ack2),
    .xmitH(xmitH2), .xmit_dataH(xdat2), .xmit_doneH(done2), .grant_o(grant2), .busy_o(busy2));

  uart_xmit_sched_of_verifla #(.NREQ(4), .BUSY_TIMEOUT(BT)) dut4 (
    .sys_clk(clk), .sys_rst_l(rst_l), .req_i(req4), .data_i(data4), .ack_o(ack4),
    .xmitH(xmitH4), .xmit_dataH(xdat4), .xmit_doneH(done4), .grant_o(grant4), .busy_o(busy4));

  int checks = 0;
  int errors = 0;

  // Producer model: requester k offers srcByte[k][pos[k]] while pos[k] < cnt[k].
  int         cnt [4];
  int         pos [4];
  logic [7:0] srcByte [4][32];
  bit         sel4, txAuto;
  int         txLen, txCnt;
  logic       manDone;
  int         mptr2, mptr4;
  int         expK[$];
  logic [7:0] expB[$];
  int         logK[$];
  logic [7:0] logB[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [3:0]  r;
    logic [31:0] d;
    logic        dn;
    r = '0;
    d = '0;
    for (int k = 0; k < 4; k++)
      if (pos[k] < cnt[k]) begin
        r[k] = 1'b1;
        d[k*8 +: 8] = srcByte[k][pos[k]];
      end
    dn = txAuto ? (txCnt == 0) : manDone;
    done2 = dn;
    done4 = dn;
    if (sel4) begin
      req4 = r; data4 = d; req2 = '0; data2 = '0;
    end else begin
      req2 = r[1:0]; data2 = d[15:0]; req4 = '0; data4 = '0;
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, log strobes,
  // advance producers on ack and the model transmitter on xmitH.
  task automatic tick();
    logic [3:0] a;
    logic       x;
    logic [7:0] xd;
    @(posedge clk);
    #1;
    a  = sel4 ? ack4 : {2'b00, ack2};
    x  = sel4 ? xmitH4 : xmitH2;
    xd = sel4 ? xdat4 : xdat2;
    chk("ack_xmit_overlap", 32'((a != 4'b0) && x), 32'd0);
    chk("ack_onehot", 32'($countones(a) <= 1), 32'd1);
    if (x) logB.push_back(xd);
    for (int k = 0; k < 4; k++)
      if (a[k]) begin
        logK.push_back(k);
        pos[k]++;
      end
    if (txAuto) begin
      if (x) txCnt = txLen;
      else if (txCnt > 0) txCnt--;
    end
    drive();
  endtask

  function automatic logic curBusy();
    return sel4 ? busy4 : busy2;
  endfunction

  function automatic logic pending();
    logic p;
    p = 1'b0;
    for (int k = 0; k < 4; k++) if (pos[k] < cnt[k]) p = 1'b1;
    return p;
  endfunction

  // Expected service order for all outstanding bytes: strict round robin
  // from the model pointer, pointer moving to one past each winner.
  task automatic plan();
    int p2 [4];
    int n, ptr, k;
    bit found;
    n   = sel4 ? 4 : 2;
    ptr = sel4 ? mptr4 : mptr2;
    for (int j = 0; j < 4; j++) p2[j] = pos[j];
    found = 1'b1;
    while (found) begin
      found = 1'b0;
      for (int i = 0; i < n; i++) begin
        k = (ptr + i) % n;
        if (!found && p2[k] < cnt[k]) begin
          found = 1'b1;
          expK.push_back(k);
          expB.push_back(srcByte[k][p2[k]]);
          p2[k]++;
          ptr = (k + 1) % n;
        end
      end
    end
    if (sel4) mptr4 = ptr;
    else      mptr2 = ptr;
  endtask

  task automatic startRun();
    expK.delete(); expB.delete(); logK.delete(); logB.delete();
  endtask

  task automatic waitIdle(input string tag, input int bound);
    int n;
    n = 0;
    while ((curBusy() || pending()) && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(n < bound), 32'd1);
  endtask

  task automatic compareRun(input string tag);
    chk({tag, "_grant_count"}, 32'(logK.size()), 32'(expK.size()));
    chk({tag, "_launch_count"}, 32'(logB.size()), 32'(expB.size()));
    for (int i = 0; i < expK.size(); i++) begin
      if (i < logK.size()) chk($sformatf("%s_grant%0d", tag, i), 32'(logK[i]), 32'(expK[i]));
      if (i < logB.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(logB[i]), 32'(expB[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold, n, c;
    int order [4] = '{2, 3, 0, 1};

    rst_l = 1'b0; sel4 = 1'b0; txAuto = 1'b0; txLen = 0; txCnt = 0;
    manDone = 1'b1; mptr2 = 0; mptr4 = 0;
    for (int k = 0; k < 4; k++) begin
      cnt[k] = 0; pos[k] = 0;
      for (int j = 0; j < 32; j++) srcByte[k][j] = 8'($urandom_range(0, 255));
    end
    drive();
    repeat (3) tick();
    chk("rst_ack2",   32'(ack2),   32'd0);
    chk("rst_xmit2",  32'(xmitH2), 32'd0);
    chk("rst_data2",  32'(xdat2),  32'd0);
    chk("rst_grant2", 32'(grant2), 32'd0);
    chk("rst_busy2",  32'(busy2),  32'd0);
    chk("rst_ack4",   32'(ack4),   32'd0);
    chk("rst_xmit4",  32'(xmitH4), 32'd0);
    chk("rst_data4",  32'(xdat4),  32'd0);
    chk("rst_grant4", 32'(grant4), 32'd0);
    chk("rst_busy4",  32'(busy4),  32'd0);

    // Single byte, long busy period from the transmitter.
    rst_l = 1'b1;
    startRun();
    srcByte[0][0] = 8'hA5; cnt[0] = 1;
    plan(); drive();
    tick();
    chk("t1_ack",      32'(ack2),   32'd1);
    chk("t1_no_xmit",  32'(xmitH2), 32'd0);
    chk("t1_data",     32'(xdat2),  32'hA5);
    chk("t1_grant",    32'(grant2), 32'd0);
    chk("t1_busy",     32'(busy2),  32'd1);
    tick();
    chk("t1_xmit",     32'(xmitH2), 32'd1);
    chk("t1_ack_low",  32'(ack2),   32'd0);
    manDone = 1'b0; drive();
    hold = 0;
    repeat (100) begin
      tick();
      if (busy2 && !xmitH2) hold++;
    end
    chk("t1_hold", 32'(hold), 32'd100);
    manDone = 1'b1; drive();
    tick();
    chk("t1_busy_fall", 32'(busy2), 32'd0);
    chk("t1_data_held", 32'(xdat2), 32'hA5);
    compareRun("t1");

    // Request while the transmitter is not ready: nothing happens until done.
    startRun();
    cnt[0] = 2; manDone = 1'b0;
    plan(); drive();
    hold = 0;
    repeat (10) begin
      tick();
      if (ack2 == 2'b00 && !xmitH2 && !busy2) hold++;
    end
    chk("t3_quiet", 32'(hold), 32'd10);
    manDone = 1'b1; drive();
    tick();
    chk("t3_ack",  32'(ack2),  32'd1);
    chk("t3_data", 32'(xdat2), 32'(srcByte[0][1]));
    tick();
    chk("t3_xmit", 32'(xmitH2), 32'd1);
    manDone = 1'b0; drive();
    tick(); tick();
    manDone = 1'b1; drive();
    waitIdle("t3", 20);
    compareRun("t3");

    // Transmitter ignores the strobe: return after BT WAIT_BUSY cycles.
    startRun();
    srcByte[1][0] = 8'h3C; cnt[1] = 1; manDone = 1'b1;
    plan(); drive();
    tick();
    chk("t4_ack",   32'(ack2),   32'd2);
    chk("t4_grant", 32'(grant2), 32'd1);
    chk("t4_data",  32'(xdat2),  32'h3C);
    tick();
    chk("t4_xmit", 32'(xmitH2), 32'd1);
    n = 0;
    while (busy2 && n < 100) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'(BT));
    chk("t4_single_launch", 32'(logB.size()), 32'd1);
    cnt[0] = pos[0] + 1;
    plan(); drive();
    tick();
    chk("t4_second_ack",  32'(ack2),  32'd1);
    chk("t4_second_data", 32'(xdat2), 32'(srcByte[0][pos[0] - 1]));
    waitIdle("t4", 100);
    compareRun("t4");

    // Both requesters streaming random bytes through a model transmitter.
    startRun();
    txAuto = 1'b1; txLen = 40; txCnt = 0;
    for (int k = 0; k < 2; k++) begin
      c = $urandom_range(2, 5);
      for (int j = 0; j < c; j++) srcByte[k][cnt[k] + j] = 8'($urandom_range(0, 255));
      cnt[k] += c;
    end
    plan(); drive();
    waitIdle("t2", 3000);
    compareRun("t2");

    // Reset in the middle of a transfer.
    startRun();
    txAuto = 1'b0; manDone = 1'b1;
    cnt[0] = pos[0] + 1;
    plan(); drive();
    tick();
    chk("t5_ack", 32'(ack2), 32'd1);
    tick();
    chk("t5_xmit", 32'(xmitH2), 32'd1);
    manDone = 1'b0; drive();
    tick(); tick();
    chk("t5_in_wait", 32'(busy2), 32'd1);
    rst_l = 1'b0;
    tick();
    chk("t5_rst_ack",   32'(ack2),   32'd0);
    chk("t5_rst_xmit",  32'(xmitH2), 32'd0);
    chk("t5_rst_data",  32'(xdat2),  32'd0);
    chk("t5_rst_grant", 32'(grant2), 32'd0);
    chk("t5_rst_busy",  32'(busy2),  32'd0);
    rst_l = 1'b1; mptr2 = 0; manDone = 1'b1;
    startRun();
    cnt[0] = pos[0] + 1; cnt[1] = pos[1] + 1;
    plan(); drive();
    tick();
    chk("t5_ptr_reset_ack",   32'(ack2),   32'd1);
    chk("t5_ptr_reset_grant", 32'(grant2), 32'd0);
    waitIdle("t5", 200);
    compareRun("t5");

    // Four requesters, pointer moved to 2 first.
    sel4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pos[k] = 0; cnt[k] = 0;
    end
    txAuto = 1'b1; txLen = $urandom_range(3, 10); txCnt = 0;
    startRun();
    cnt[1] = 1;
    plan(); drive();
    waitIdle("t6a", 200);
    compareRun("t6a");
    startRun();
    for (int k = 0; k < 4; k++) cnt[k] += 2;
    plan(); drive();
    waitIdle("t6", 2000);
    compareRun("t6");
    for (int i = 0; i < 4; i++)
      if (i < logK.size()) chk($sformatf("t6_order%0d", i), 32'(logK[i]), 32'(order[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
